// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the five-stage CPU.
// Produces register write enables and flushes for the PC and the four pipeline
// registers, EX-stage forwarding selects, and three saturating event counters.
//
// Per-cycle priority (highest first): reset, memory freeze, branch flush,
// load-use stall, normal run. A branch that resolves while the data memory is
// busy is remembered in pending_flush and applied in the first non-busy cycle.
//
// The FSM {RUN, FREEZE} and pending_flush are exposed on dbgState as
// {pending_flush, state == FREEZE} so checkers can observe them directly.
//
// Handshake note: there is no valid/ready traffic on this block. memBusy acts as
// a level-sensitive "not ready" from the data memory: while it is high every
// pipeline register holds; the cycle in which it is low is the cycle that
// advances, and any remembered branch flush is applied in that same cycle.
module hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifidRn,
  input  logic [4:0]       ifidRm,
  input  logic             ifidUseRm,
  input  logic [4:0]       idexRn,
  input  logic [4:0]       idexRm,
  input  logic [4:0]       idexRd,
  input  logic             idexMemRead,
  input  logic [4:0]       exmemRd,
  input  logic             exmemRegWrite,
  input  logic [4:0]       memwrRd,
  input  logic             memwrRegWrite,
  input  logic             branchTaken,
  input  logic             memBusy,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             idexWrite,
  output logic             exmemWrite,
  output logic             memwrWrite,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             exmemFlush,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt,
  output logic [CNT_W-1:0] freezeCnt,
  output logic [1:0]       dbgState
);

  localparam logic [4:0] ZERO = 5'(ZERO_REG);

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic   pending_flush;
  logic   pending_next;

  // Hazard terms and the single active rule for this cycle.
  logic load_use;
  logic do_flush;
  logic rule_freeze;
  logic rule_flush;
  logic rule_stall;

  assign load_use = idexMemRead && (idexRd != ZERO) &&
                    ((idexRd == ifidRn) || (ifidUseRm && (idexRd == ifidRm)));
  assign do_flush = branchTaken || pending_flush;

  // Reset masks every rule so the counters and outputs stay quiet during reset.
  assign rule_freeze = !reset && memBusy;
  assign rule_flush  = !reset && !memBusy && do_flush;
  assign rule_stall  = !reset && !memBusy && !do_flush && load_use;

  assign dbgState = {pending_flush, (state == FREEZE)};

  // State register: FSM state and the remembered branch flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      pending_flush <= 1'b0;
    end else begin
      state         <= state_next;
      pending_flush <= pending_next;
    end
  end

  // Next-state logic and pipeline control outputs.
  always_comb begin
    state_next   = state;
    pending_next = pending_flush;
    pcWrite      = 1'b0;
    ifidWrite    = 1'b0;
    idexWrite    = 1'b0;
    exmemWrite   = 1'b0;
    memwrWrite   = 1'b0;
    ifidFlush    = 1'b0;
    idexFlush    = 1'b0;
    exmemFlush   = 1'b0;

    case (state)
      RUN:    if (memBusy) state_next = FREEZE;
      FREEZE: if (!memBusy) state_next = RUN;
      default: state_next = RUN;
    endcase

    // A branch seen while busy is held until the first free cycle, where
    // the flush below consumes it. Holding branchTaken high over several
    // busy cycles just keeps the same bit set, so only one flush results.
    if (memBusy) begin
      pending_next = pending_flush || branchTaken;
    end else begin
      pending_next = 1'b0;
    end

    if (reset || rule_freeze) begin
      // All enables and flushes stay 0: the whole pipeline holds.
    end else if (rule_flush) begin
      pcWrite    = 1'b1;
      ifidWrite  = 1'b1;
      idexWrite  = 1'b1;
      exmemWrite = 1'b1;
      memwrWrite = 1'b1;
      ifidFlush  = 1'b1;
      idexFlush  = 1'b1;
      exmemFlush = 1'b1;
    end else if (rule_stall) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX.
      idexWrite  = 1'b1;
      exmemWrite = 1'b1;
      memwrWrite = 1'b1;
      idexFlush  = 1'b1;
    end else begin
      pcWrite    = 1'b1;
      ifidWrite  = 1'b1;
      idexWrite  = 1'b1;
      exmemWrite = 1'b1;
      memwrWrite = 1'b1;
    end
  end

  // EX-stage forwarding; the younger EX/MEM result wins over MEM/WR.
  always_comb begin
    forwardA = 2'b00;
    forwardB = 2'b00;
    if (!reset) begin
      if (exmemRegWrite && (exmemRd != ZERO) && (exmemRd == idexRn)) begin
        forwardA = 2'b10;
      end else if (memwrRegWrite && (memwrRd != ZERO) && (memwrRd == idexRn)) begin
        forwardA = 2'b01;
      end

      if (exmemRegWrite && (exmemRd != ZERO) && (exmemRd == idexRm)) begin
        forwardB = 2'b10;
      end else if (memwrRegWrite && (memwrRd != ZERO) && (memwrRd == idexRm)) begin
        forwardB = 2'b01;
      end
    end
  end

  // Saturating event counters, one per non-run rule.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt  <= '0;
      flushCnt  <= '0;
      freezeCnt <= '0;
    end else begin
      if (rule_stall && (stallCnt != '1)) begin
        stallCnt <= stallCnt + 1'b1;
      end
      if (rule_flush && (flushCnt != '1)) begin
        flushCnt <= flushCnt + 1'b1;
      end
      if (rule_freeze && (freezeCnt != '1)) begin
        freezeCnt <= freezeCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed, table-driven bench for hazard_ctrl.
// Inputs change on the falling edge; outputs are sampled 1 ns later, well
// away from the rising edge that consumes them.
module tb_hazard_ctrl;

  localparam int CNT_W = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] ifidRn, ifidRm, idexRn, idexRm, idexRd, exmemRd, memwrRd;
  logic       ifidUseRm, idexMemRead, exmemRegWrite, memwrRegWrite;
  logic       branchTaken, memBusy;
  logic       pcWrite, ifidWrite, idexWrite, exmemWrite, memwrWrite;
  logic       ifidFlush, idexFlush, exmemFlush;
  logic [1:0] forwardA, forwardB, dbgState;
  logic [CNT_W-1:0] stallCnt, flushCnt, freezeCnt;

  hazard_ctrl #(.CNT_W(CNT_W), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset),
    .ifidRn(ifidRn), .ifidRm(ifidRm), .ifidUseRm(ifidUseRm),
    .idexRn(idexRn), .idexRm(idexRm), .idexRd(idexRd), .idexMemRead(idexMemRead),
    .exmemRd(exmemRd), .exmemRegWrite(exmemRegWrite),
    .memwrRd(memwrRd), .memwrRegWrite(memwrRegWrite),
    .branchTaken(branchTaken), .memBusy(memBusy),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexWrite(idexWrite),
    .exmemWrite(exmemWrite), .memwrWrite(memwrWrite),
    .ifidFlush(ifidFlush), .idexFlush(idexFlush), .exmemFlush(exmemFlush),
    .forwardA(forwardA), .forwardB(forwardB),
    .stallCnt(stallCnt), .flushCnt(flushCnt), .freezeCnt(freezeCnt),
    .dbgState(dbgState)
  );

  // Scoreboard counters
  int checks   = 0;
  int failures = 0;

  logic [4:0] en;
  logic [2:0] fl;
  assign en = {pcWrite, ifidWrite, idexWrite, exmemWrite, memwrWrite};
  assign fl = {ifidFlush, idexFlush, exmemFlush};

  typedef struct {
    logic [4:0] ifid_rn, ifid_rm;
    logic       ifid_use_rm;
    logic [4:0] idex_rn, idex_rm, idex_rd;
    logic       idex_mem_read;
    logic [4:0] exmem_rd;
    logic       exmem_rw;
    logic [4:0] memwr_rd;
    logic       memwr_rw;
    logic       branch;
    logic       busy;
    logic [4:0] exp_en;
    logic [2:0] exp_fl;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [4:0] frn, input logic [4:0] frm, input logic use_rm,
    input logic [4:0] xrn, input logic [4:0] xrm, input logic [4:0] xrd, input logic mr,
    input logic [4:0] mrd, input logic mrw, input logic [4:0] wrd, input logic wrw,
    input logic br, input logic bsy,
    input logic [4:0] e_en, input logic [2:0] e_fl, input logic [1:0] e_fa, input logic [1:0] e_fb);
    vec_t v;
    v.ifid_rn = frn; v.ifid_rm = frm; v.ifid_use_rm = use_rm;
    v.idex_rn = xrn; v.idex_rm = xrm; v.idex_rd = xrd; v.idex_mem_read = mr;
    v.exmem_rd = mrd; v.exmem_rw = mrw; v.memwr_rd = wrd; v.memwr_rw = wrw;
    v.branch = br; v.busy = bsy;
    v.exp_en = e_en; v.exp_fl = e_fl; v.exp_fa = e_fa; v.exp_fb = e_fb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Driver tasks
  task automatic idle();
    ifidRn = 0; ifidRm = 0; ifidUseRm = 0;
    idexRn = 0; idexRm = 0; idexRd = 0; idexMemRead = 0;
    exmemRd = 0; exmemRegWrite = 0; memwrRd = 0; memwrRegWrite = 0;
    branchTaken = 0; memBusy = 0;
  endtask

  task automatic apply(input vec_t v);
    ifidRn = v.ifid_rn; ifidRm = v.ifid_rm; ifidUseRm = v.ifid_use_rm;
    idexRn = v.idex_rn; idexRm = v.idex_rm; idexRd = v.idex_rd;
    idexMemRead = v.idex_mem_read;
    exmemRd = v.exmem_rd; exmemRegWrite = v.exmem_rw;
    memwrRd = v.memwr_rd; memwrRegWrite = v.memwr_rw;
    branchTaken = v.branch; memBusy = v.busy;
  endtask

  // Advance through one rising edge and stop on the next falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_load_use();
    idle();
    idexMemRead = 1; idexRd = 5; ifidRn = 5;
  endtask

  initial begin
    reset = 1'b1;
    idle();

    // Table: {inputs, expected en, fl, forwardA, forwardB}
    //          frn frm u xrn xrm xrd mr mrd mrw wrd wrw br bsy   en        fl      fa     fb
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'b00, 2'b00)); // idle
    vecs.push_back(mk(5, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 5'b00111, 3'b010, 2'b00, 2'b00)); // load-use Rn
    vecs.push_back(mk(1, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 5'b00111, 3'b010, 2'b00, 2'b00)); // load-use Rm
    vecs.push_back(mk(1, 5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'b00, 2'b00)); // Rm unused
    vecs.push_back(mk(31, 0, 0, 0, 0, 31, 1, 0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'b00, 2'b00)); // zero reg
    vecs.push_back(mk(5, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'b00, 2'b00)); // not a load
    vecs.push_back(mk(0, 0, 0, 3, 4, 0, 0, 3, 1, 3, 1, 0, 0, 5'b11111, 3'b000, 2'b10, 2'b00)); // exmem wins
    vecs.push_back(mk(0, 0, 0, 3, 4, 0, 0, 3, 0, 3, 1, 0, 0, 5'b11111, 3'b000, 2'b01, 2'b00)); // memwr
    vecs.push_back(mk(0, 0, 0, 3, 4, 0, 0, 4, 1, 3, 1, 0, 0, 5'b11111, 3'b000, 2'b01, 2'b10)); // split
    vecs.push_back(mk(0, 0, 0, 31, 31, 0, 0, 31, 1, 31, 1, 0, 0, 5'b11111, 3'b000, 2'b00, 2'b00)); // zero reg fwd
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11111, 3'b111, 2'b00, 2'b00)); // branch
    vecs.push_back(mk(5, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 5'b11111, 3'b111, 2'b00, 2'b00)); // branch+load-use
    vecs.push_back(mk(0, 0, 0, 3, 0, 0, 0, 3, 1, 0, 0, 0, 1, 5'b00000, 3'b000, 2'b10, 2'b00)); // busy, fwd live
    vecs.push_back(mk(5, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 5'b00000, 3'b000, 2'b00, 2'b00)); // busy+load-use

    // Reset behaviour: outputs held quiet even with hazards present.
    @(negedge clk);
    exmemRegWrite = 1; exmemRd = 3; idexRn = 3; branchTaken = 1;
    #1;
    chk("reset_en", en, 5'b00000);
    chk("reset_fl", fl, 3'b000);
    chk("reset_fa", forwardA, 2'b00);
    step();
    step();
    reset = 1'b0;
    idle();
    #1;
    chk("idle_en", en, 5'b11111);
    chk("idle_fl", fl, 3'b000);
    chk("idle_fa", {forwardA, forwardB}, 4'b0000);
    chk("idle_cnts", {stallCnt, flushCnt, freezeCnt}, 48'd0);
    chk("idle_state", dbgState, 2'b00);

    // Table-driven combinational checks.
    foreach (vecs[i]) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("vec%0d_en", i), en, vecs[i].exp_en);
      chk($sformatf("vec%0d_fl", i), fl, vecs[i].exp_fl);
      chk($sformatf("vec%0d_fa", i), forwardA, vecs[i].exp_fa);
      chk($sformatf("vec%0d_fb", i), forwardB, vecs[i].exp_fb);
      step();
    end

    // Single load-use stall increments stallCnt by one.
    do_reset();
    set_load_use();
    step();
    idle();
    #1;
    chk("stall_cnt1", stallCnt, 16'd1);
    chk("stall_flush0", flushCnt, 16'd0);
    chk("stall_after_en", en, 5'b11111);

    // Freeze 3 cycles with a branch in the second busy cycle.
    do_reset();
    memBusy = 1;
    #1;
    chk("frz1_en", en, 5'b00000);
    step();
    branchTaken = 1;
    #1;
    chk("frz2_en", en, 5'b00000);
    chk("frz2_fl", fl, 3'b000);
    chk("frz2_state", dbgState, 2'b01);
    step();
    branchTaken = 0;
    #1;
    chk("frz3_en", en, 5'b00000);
    chk("frz3_state", dbgState, 2'b11);
    step();
    memBusy = 0;
    #1;
    chk("rel_fl", fl, 3'b111);
    chk("rel_en", en, 5'b11111);
    chk("rel_freeze_cnt", freezeCnt, 16'd3);
    step();
    #1;
    chk("post_fl", fl, 3'b000);
    chk("post_flush_cnt", flushCnt, 16'd1);
    chk("post_state", dbgState, 2'b00);

    // Branch held across two busy cycles and the release: one flush only.
    do_reset();
    memBusy = 1; branchTaken = 1;
    step();
    step();
    memBusy = 0;
    #1;
    chk("hold_rel_fl", fl, 3'b111);
    step();
    branchTaken = 0;
    #1;
    chk("hold_post_fl", fl, 3'b000);
    step();
    chk("hold_flush_cnt", flushCnt, 16'd1);
    chk("hold_freeze_cnt", freezeCnt, 16'd2);

    // Branch and load-use together: flush wins, stallCnt untouched.
    do_reset();
    set_load_use();
    branchTaken = 1;
    #1;
    chk("both_fl", fl, 3'b111);
    chk("both_en", en, 5'b11111);
    step();
    idle();
    #1;
    chk("both_stall_cnt", stallCnt, 16'd0);
    chk("both_flush_cnt", flushCnt, 16'd1);

    // Reset during a freeze with a pending flush discards both.
    do_reset();
    memBusy = 1; branchTaken = 1;
    step();
    do_reset();
    #1;
    chk("rst_pend_state", dbgState, 2'b00);
    chk("rst_pend_fl", fl, 3'b000);

    // Saturation: 2^CNT_W + 5 stall cycles, then reset clears it.
    do_reset();
    set_load_use();
    repeat ((1 << CNT_W) + 5) step();
    #1;
    chk("sat_stall_cnt", stallCnt, {CNT_W{1'b1}});
    do_reset();
    #1;
    chk("sat_reset_cnt", stallCnt, 16'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
